// File: rtl/arf_sequencer.sv
// ---------------------------------------------------------------------------
// arf_sequencer
//   Drives the three-register address file (PC, SP, AR) and the byte-wide
//   memory for the top-level controller. It takes one command at a time
//   over a valid/ready handshake. It then steps the address file controls
//   and the memory strobes through a short fixed sequence.
//
//   Commands : 000 NOP, 001 FETCH, 010 PUSH, 011 POP, 100 ARINC, 101 CLRPC,
//              110/111 illegal (Err pulse, no activity)
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd    command request; accepted when cmd_valid & cmd_ready
//   cmd_ready        high only while idle
//   wr_data          PUSH word, latched on accept
//   mem_rd_data      combinational memory read byte at the OutD address
//   arf_funsel       00 dec, 01 inc, 10 load, 11 clear
//   arf_regsel       enables [2]=PC [1]=SP [0]=AR
//   arf_outcsel      fixed to AR
//   arf_outdsel      memory address source: 00 PC, 01 SP
//   mem_ce/mem_wr    memory enable / write strobe
//   mem_wr_data      byte being written
//   ir, pop_data     last fetched instruction / last popped word
//   done, err        one-cycle completion / illegal-command pulses
// ---------------------------------------------------------------------------
module arf_sequencer #(
    parameter int CMD_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd,
    output logic             cmd_ready,
    input  logic [15:0]      wr_data,
    input  logic [7:0]       mem_rd_data,
    output logic [1:0]       arf_funsel,
    output logic [2:0]       arf_regsel,
    output logic [1:0]       arf_outcsel,
    output logic [1:0]       arf_outdsel,
    output logic             mem_ce,
    output logic             mem_wr,
    output logic [7:0]       mem_wr_data,
    output logic [15:0]      ir,
    output logic [15:0]      pop_data,
    output logic             done,
    output logic             err
);

    localparam logic [CMD_W-1:0] C_NOP   = CMD_W'(0);
    localparam logic [CMD_W-1:0] C_FETCH = CMD_W'(1);
    localparam logic [CMD_W-1:0] C_PUSH  = CMD_W'(2);
    localparam logic [CMD_W-1:0] C_POP   = CMD_W'(3);
    localparam logic [CMD_W-1:0] C_ARINC = CMD_W'(4);
    localparam logic [CMD_W-1:0] C_CLRPC = CMD_W'(5);

    localparam logic [1:0] FS_DEC = 2'b00;
    localparam logic [1:0] FS_INC = 2'b01;
    localparam logic [1:0] FS_CLR = 2'b11;

    localparam logic [2:0] RS_NONE = 3'b000;
    localparam logic [2:0] RS_PC   = 3'b100;
    localparam logic [2:0] RS_SP   = 3'b010;
    localparam logic [2:0] RS_AR   = 3'b001;

    localparam logic [1:0] OD_PC = 2'b00;
    localparam logic [1:0] OD_SP = 2'b01;

    typedef enum logic [3:0] {
        S_IDLE, S_F1, S_F2, S_P1, S_P2, S_P3, S_Q1, S_Q2, S_SINGLE, S_FIN
    } state_t;

    // Moore control bundle decoded from the state
    typedef struct packed {
        logic [1:0] funsel;
        logic [2:0] regsel;
        logic [1:0] outdsel;
        logic       ce;
        logic       wr;
        logic [7:0] wdata;
    } ctl_t;

    state_t           state, nxt;
    ctl_t             ctl;
    logic [15:0]      wr_q;
    logic [CMD_W-1:0] cmd_q;
    logic             accept;
    logic             cmd_illegal;

    assign accept      = cmd_valid & cmd_ready;
    // Any code above CLRPC is illegal
    assign cmd_illegal = (cmd_q > C_CLRPC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Command/data capture. Memory read bytes are taken at the edge that
    // ends the cycle addressing them. The address file steps the pointer
    // on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= '0;
            cmd_q    <= '0;
            ir       <= '0;
            pop_data <= '0;
        end else begin
            if (accept) begin
                wr_q  <= wr_data;
                cmd_q <= cmd;
            end
            case (state)
                S_F1:    ir[7:0]        <= mem_rd_data;
                S_F2:    ir[15:8]       <= mem_rd_data;
                S_Q1:    pop_data[7:0]  <= mem_rd_data;
                S_Q2:    pop_data[15:8] <= mem_rd_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt       = state;
        ctl       = '0;
        cmd_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd)
                        C_FETCH: nxt = S_F1;
                        C_PUSH:  nxt = S_P1;
                        C_POP:   nxt = S_Q1;
                        C_ARINC: nxt = S_SINGLE;
                        C_CLRPC: nxt = S_SINGLE;
                        default: nxt = S_FIN;   // NOP and illegal codes
                    endcase
                end
            end
            S_F1, S_F2: begin
                ctl.outdsel = OD_PC;
                ctl.ce      = 1'b1;
                ctl.regsel  = RS_PC;
                ctl.funsel  = FS_INC;
                nxt         = (state == S_F1) ? S_F2 : S_FIN;
            end
            // Full-descending stack: pre-decrement before the high byte.
            // Decrement again before the low byte.
            S_P1: begin
                ctl.regsel = RS_SP;
                ctl.funsel = FS_DEC;
                nxt        = S_P2;
            end
            S_P2: begin
                ctl.outdsel = OD_SP;
                ctl.ce      = 1'b1;
                ctl.wr      = 1'b1;
                ctl.wdata   = wr_q[15:8];
                ctl.regsel  = RS_SP;
                ctl.funsel  = FS_DEC;
                nxt         = S_P3;
            end
            S_P3: begin
                ctl.outdsel = OD_SP;
                ctl.ce      = 1'b1;
                ctl.wr      = 1'b1;
                ctl.wdata   = wr_q[7:0];
                nxt         = S_FIN;
            end
            // Pop reads low byte then high byte, post-incrementing SP
            S_Q1, S_Q2: begin
                ctl.outdsel = OD_SP;
                ctl.ce      = 1'b1;
                ctl.regsel  = RS_SP;
                ctl.funsel  = FS_INC;
                nxt         = (state == S_Q1) ? S_Q2 : S_FIN;
            end
            S_SINGLE: begin
                if (cmd_q == C_CLRPC) begin
                    ctl.regsel = RS_PC;
                    ctl.funsel = FS_CLR;
                end else begin
                    ctl.regsel = RS_AR;
                    ctl.funsel = FS_INC;
                end
                nxt = S_FIN;
            end
            S_FIN: begin
                done = 1'b1;
                err  = cmd_illegal;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign arf_funsel  = ctl.funsel;
    assign arf_regsel  = ctl.regsel;
    assign arf_outcsel = 2'b10;
    assign arf_outdsel = ctl.outdsel;
    assign mem_ce      = ctl.ce;
    assign mem_wr      = ctl.wr;
    assign mem_wr_data = ctl.wdata;

    // NOP carries no extra behaviour beyond the FIN pulse
    logic unused_nop;
    assign unused_nop = (cmd_q == C_NOP);

endmodule

// File: tb/tb_arf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_arf_sequencer
//   Bench for arf_sequencer. It builds a small address-file and memory
//   environment that reacts to the sequencer controls. The main checks
//   come from a table of directed cases with hand-derived results. A few
//   hand-written sequences cover reset during PUSH and a held CmdValid.
//   A randomized run is checked against a command-level model of PC, SP,
//   AR, memory, IR and PopData.
// ---------------------------------------------------------------------------
module tb_arf_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic        cmd_ready;
    logic [15:0] wr_data;
    logic [7:0]  mem_rd_data;
    logic [1:0]  arf_funsel;
    logic [2:0]  arf_regsel;
    logic [1:0]  arf_outcsel;
    logic [1:0]  arf_outdsel;
    logic        mem_ce;
    logic        mem_wr;
    logic [7:0]  mem_wr_data;
    logic [15:0] ir;
    logic [15:0] pop_data;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    arf_sequencer #(.CMD_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .wr_data(wr_data), .mem_rd_data(mem_rd_data),
        .arf_funsel(arf_funsel), .arf_regsel(arf_regsel),
        .arf_outcsel(arf_outcsel), .arf_outdsel(arf_outdsel),
        .mem_ce(mem_ce), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
        .ir(ir), .pop_data(pop_data), .done(done), .err(err)
    );

    // ---------------- environment: address file + memory ----------------
    bit   [7:0]  mem [0:65535];
    logic [15:0] pc, sp, ar;
    logic        ld, mld;
    logic [15:0] ld_pc, ld_sp, ld_ar, mla;
    logic [7:0]  mld_d;
    logic [15:0] addr;

    function automatic logic [15:0] fupd(input logic [15:0] v, input logic [1:0] fs);
        case (fs)
            2'b00:   return v - 16'd1;
            2'b01:   return v + 16'd1;
            2'b11:   return 16'd0;
            default: return v;
        endcase
    endfunction

    assign addr        = (arf_outdsel == 2'b01) ? sp : (arf_outdsel == 2'b00) ? pc : ar;
    assign mem_rd_data = mem[addr];

    always @(posedge clk) begin
        if (ld) begin
            pc <= ld_pc; sp <= ld_sp; ar <= ld_ar;
        end else begin
            if (arf_regsel[2]) pc <= fupd(pc, arf_funsel);
            if (arf_regsel[1]) sp <= fupd(sp, arf_funsel);
            if (arf_regsel[0]) ar <= fupd(ar, arf_funsel);
        end
        if (mld) mem[mla] <= mld_d;
        else if (mem_ce && mem_wr) mem[addr] <= mem_wr_data;
    end

    // ---------------- reference model (command level) ----------------
    bit   [7:0]  ref_mem [0:65535];
    logic [15:0] m_pc, m_sp, m_ar, m_ir, m_pop;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [2:0] c);
        case (c)
            3'd1, 3'd3: return 3;
            3'd2:       return 4;
            3'd4, 3'd5: return 2;
            default:    return 1;
        endcase
    endfunction

    function automatic int nce_of(input logic [2:0] c);
        return (c == 3'd1 || c == 3'd2 || c == 3'd3) ? 2 : 0;
    endfunction

    task automatic apply_model(input logic [2:0] c, input logic [15:0] wd);
        logic [15:0] a0, a1;
        case (c)
            3'd1: begin
                a0 = m_pc; a1 = m_pc + 16'd1;
                m_ir = {ref_mem[a1], ref_mem[a0]};
                m_pc = m_pc + 16'd2;
            end
            3'd2: begin
                a1 = m_sp - 16'd1; a0 = m_sp - 16'd2;
                ref_mem[a1] = wd[15:8];
                ref_mem[a0] = wd[7:0];
                m_sp = m_sp - 16'd2;
            end
            3'd3: begin
                a0 = m_sp; a1 = m_sp + 16'd1;
                m_pop = {ref_mem[a1], ref_mem[a0]};
                m_sp = m_sp + 16'd2;
            end
            3'd4: m_ar = m_ar + 16'd1;
            3'd5: m_pc = 16'd0;
            default: ;
        endcase
    endtask

    task automatic check_model();
        logic [15:0] a0, a1;
        a0 = m_sp; a1 = m_sp + 16'd1;
        chk("m_pc", pc, m_pc);
        chk("m_sp", sp, m_sp);
        chk("m_ar", ar, m_ar);
        chk("m_ir", ir, m_ir);
        chk("m_pop", pop_data, m_pop);
        chk("m_mem_sp", mem[a0], ref_mem[a0]);
        chk("m_mem_sp1", mem[a1], ref_mem[a1]);
    endtask

    task automatic load_regs(input logic [15:0] p, input logic [15:0] s, input logic [15:0] a);
        @(negedge clk);
        ld = 1'b1; ld_pc = p; ld_sp = s; ld_ar = a;
        @(posedge clk); #1;
        ld = 1'b0;
        m_pc = p; m_sp = s; m_ar = a;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        mld = 1'b1; mla = a; mld_d = d;
        @(posedge clk); #1;
        mld = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issue one command and follow it to its Done pulse
    task automatic run_cmd(input logic [2:0] c, input logic [15:0] wd,
                           output int lat, output int nce,
                           output bit err_done, output bit err_other, output bit anysel);
        int w;
        lat = 0; nce = 0; err_done = 0; err_other = 0; anysel = 0; w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        chk("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd = c; wr_data = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = 3'd0; wr_data = 16'($urandom);
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (mem_ce) nce++;
            if (arf_regsel != 3'b000) anysel = 1;
            if (err && done) err_done = 1;
            if (err && !done) err_other = 1;
            if (done) break;
        end
        @(negedge clk);
        chk("done_single", done, 0);
        chk("ready_after", cmd_ready, 1);
    endtask

    typedef struct {
        bit          ld;
        logic [15:0] pc, sp, ar;
        logic [2:0]  c;
        logic [15:0] wd;
        logic [15:0] e_pc, e_sp, e_ar, e_ir, e_pop;
        int          e_lat;
        int          e_nce;
        bit          e_err;
    } vec_t;

    vec_t tbl [10];

    initial begin : wd_timer
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int lat, nce, acc, n;
        bit ed, eo, sel, gotdone;
        logic [2:0] c;
        logic [15:0] wd;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; wr_data = 16'd0;
        ld = 1'b0; mld = 1'b0; ld_pc = '0; ld_sp = '0; ld_ar = '0; mla = '0; mld_d = '0;
        m_pc = '0; m_sp = '0; m_ar = '0; m_ir = '0; m_pop = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ce", mem_ce, 0);
        chk("rst_sel", arf_regsel, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_ir", ir, 0);
        chk("rst_pop", pop_data, 0);
        chk("rst_err", err, 0);
        chk("rst_outc", arf_outcsel, 2'b10);
        chk("rst_outd", arf_outdsel, 0);
        chk("rst_fs", arf_funsel, 0);

        // ---------------- directed table ----------------
        tbl[0] = '{1, 16'h0010, 16'h0100, 16'h0000, 3'd1, 16'h0000,
                   16'h0012, 16'h0100, 16'h0000, 16'h1234, 16'h0000, 3, 2, 0};
        tbl[1] = '{0, 16'h0, 16'h0, 16'h0, 3'd2, 16'hBEEF,
                   16'h0012, 16'h00FE, 16'h0000, 16'h1234, 16'h0000, 4, 2, 0};
        tbl[2] = '{0, 16'h0, 16'h0, 16'h0, 3'd3, 16'h0000,
                   16'h0012, 16'h0100, 16'h0000, 16'h1234, 16'hBEEF, 3, 2, 0};
        tbl[3] = '{1, 16'h7777, 16'h0001, 16'hFFFF, 3'd2, 16'hA55A,
                   16'h7777, 16'hFFFF, 16'hFFFF, 16'h1234, 16'hBEEF, 4, 2, 0};
        tbl[4] = '{0, 16'h0, 16'h0, 16'h0, 3'd3, 16'h0000,
                   16'h7777, 16'h0001, 16'hFFFF, 16'h1234, 16'hA55A, 3, 2, 0};
        tbl[5] = '{0, 16'h0, 16'h0, 16'h0, 3'd5, 16'h0000,
                   16'h0000, 16'h0001, 16'hFFFF, 16'h1234, 16'hA55A, 2, 0, 0};
        tbl[6] = '{0, 16'h0, 16'h0, 16'h0, 3'd4, 16'h0000,
                   16'h0000, 16'h0001, 16'h0000, 16'h1234, 16'hA55A, 2, 0, 0};
        tbl[7] = '{0, 16'h0, 16'h0, 16'h0, 3'd6, 16'h1111,
                   16'h0000, 16'h0001, 16'h0000, 16'h1234, 16'hA55A, 1, 0, 1};
        tbl[8] = '{0, 16'h0, 16'h0, 16'h0, 3'd7, 16'h2222,
                   16'h0000, 16'h0001, 16'h0000, 16'h1234, 16'hA55A, 1, 0, 1};
        tbl[9] = '{0, 16'h0, 16'h0, 16'h0, 3'd0, 16'h3333,
                   16'h0000, 16'h0001, 16'h0000, 16'h1234, 16'hA55A, 1, 0, 0};

        poke(16'h0010, 8'h34);
        poke(16'h0011, 8'h12);
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].ld) load_regs(tbl[i].pc, tbl[i].sp, tbl[i].ar);
            run_cmd(tbl[i].c, tbl[i].wd, lat, nce, ed, eo, sel);
            apply_model(tbl[i].c, tbl[i].wd);
            chk("t_lat", lat, tbl[i].e_lat);
            chk("t_nce", nce, tbl[i].e_nce);
            chk("t_err", ed, tbl[i].e_err);
            chk("t_err_stray", eo, 0);
            chk("t_sel", sel, (tbl[i].e_lat > 1) ? 1 : 0);
            chk("t_pc", pc, tbl[i].e_pc);
            chk("t_sp", sp, tbl[i].e_sp);
            chk("t_ar", ar, tbl[i].e_ar);
            chk("t_ir", ir, tbl[i].e_ir);
            chk("t_pop", pop_data, tbl[i].e_pop);
        end
        chk("mem_ff", mem[16'h00FF], 8'hBE);
        chk("mem_fe", mem[16'h00FE], 8'hEF);
        chk("mem_0000", mem[16'h0000], 8'hA5);
        chk("mem_ffff", mem[16'hFFFF], 8'h5A);

        // ---------------- CmdValid held through FETCH ----------------
        poke(16'h0400, 8'hC3);
        poke(16'h0401, 8'h9D);
        load_regs(16'h0400, 16'h0200, 16'h0055);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 3'd1; wr_data = 16'h0;
        acc = 0; n = 0; gotdone = 0;
        while (n < 12) begin
            if (cmd_ready) begin
                if (gotdone) break;
                acc++;
            end
            @(negedge clk);
            n++;
            if (done) gotdone = 1;
        end
        cmd_valid = 1'b0; cmd = 3'd0;
        apply_model(3'd1, 16'h0);
        chk("hold_accepts", acc, 1);
        chk("hold_done", gotdone, 1);
        chk("hold_pc", pc, 16'h0402);
        chk("hold_ir", ir, 16'h9DC3);

        // ---------------- reset during P2 of a PUSH ----------------
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 3'd2; wr_data = 16'h1357;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = 3'd0;
        @(posedge clk); #1;
        chk("p2_reached", {mem_ce, mem_wr, arf_outdsel}, 4'b1101);
        chk("p2_wdata", mem_wr_data, 8'h13);
        rst_n = 1'b0;
        #1;
        chk("arst_ce", mem_ce, 0);
        chk("arst_sel", arf_regsel, 0);
        chk("arst_done", done, 0);
        chk("arst_ir", ir, 0);
        chk("arst_pop", pop_data, 0);
        n = 0;
        repeat (3) begin @(negedge clk); if (mem_ce) n++; end
        chk("arst_no_ce", n, 0);
        // SP was decremented once (P1) and is not rolled back
        m_sp = m_sp - 16'd1; m_ir = 16'd0; m_pop = 16'd0;
        chk("arst_sp", sp, m_sp);
        chk("arst_mem", mem[m_sp], ref_mem[m_sp]);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", cmd_ready, 1);
        chk("rel_ir", ir, 0);
        chk("rel_pop", pop_data, 0);

        // ---------------- randomized run vs model ----------------
        for (int k = 0; k < 300; k++) begin
            if (($urandom % 16) == 0)
                load_regs(16'($urandom), 16'($urandom), 16'($urandom));
            c  = 3'($urandom_range(0, 7));
            wd = 16'($urandom);
            run_cmd(c, wd, lat, nce, ed, eo, sel);
            apply_model(c, wd);
            chk("r_lat", lat, lat_of(c));
            chk("r_nce", nce, nce_of(c));
            chk("r_err", ed, (c >= 3'd6) ? 1 : 0);
            chk("r_err_stray", eo, 0);
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arf_sequencer.md
Name: arf_sequencer

Overview:
- Control-side initiator for the 3-register address file (PC, SP, AR).
- Accepts one-word commands over a valid/ready handshake.
- Generates the FunSel/RegSel/OutCSel/OutDSel control stream and the byte-wide memory strobes for instruction fetch, stack push/pop and pointer maintenance.
- Captures fetched instruction bytes and popped data.
- Sits between the top-level controller and the address register file / 8-bit memory; the address file's OutD drives the memory address.

Parameters:
- CMD_W, 3, command width (fixed encoding below).

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- CmdValid  in  1  command present
- Cmd  in  3  command code
- CmdReady  out  1  sequencer can accept a command
- WrData  in  16  data for PUSH, sampled on accept
- MemRdData  in  8  combinational memory read data at the current OutD address
- ArfFunSel  out  2  to address file: 00 dec, 01 inc, 10 load, 11 clear
- ArfRegSel  out  3  active-high enables: [2]=PC, [1]=SP, [0]=AR
- ArfOutCSel  out  2  constant 2'b10 (AR)
- ArfOutDSel  out  2  memory address source: 00 PC, 01 SP
- MemCE  out  1  memory access enable, active-high
- MemWR  out  1  1=write, 0=read; meaningful only with MemCE
- MemWrData  out  8  write byte
- IR  out  16  last fetched instruction
- PopData  out  16  last popped word
- Done  out  1  one-cycle completion pulse
- Err  out  1  one-cycle illegal-command pulse

Behaviour:
- Command codes:
  - 000 NOP
  - 001 FETCH
  - 010 PUSH
  - 011 POP
  - 100 ARINC
  - 101 CLRPC
  - 110/111 illegal
- States: IDLE, F1, F2, P1, P2, P3, Q1, Q2, SINGLE, FIN.
- Accept:
  - CmdReady=1 only in IDLE.
  - A command is accepted on the rising edge where CmdValid & CmdReady.
  - WrData is latched at that edge.
  - CmdValid while busy is ignored; no queueing.
- All Arf*/Mem* outputs are Moore, decoded from the state.
- In IDLE and FIN: ArfRegSel=000, MemCE=0, ArfFunSel=00, ArfOutDSel=00.
- FETCH (little-endian):
  - F1: OutDSel=00, MemCE=1, MemWR=0; IR[7:0]<=MemRdData at edge; RegSel=100, FunSel=01.
  - F2: same controls; IR[15:8]<=MemRdData.
  - Then FIN.
- PUSH (full-descending stack, SP points at last written byte):
  - P1: RegSel=010, FunSel=00, no memory access.
  - P2: OutDSel=01, MemCE=1, MemWR=1, MemWrData=latched WrData[15:8]; RegSel=010, FunSel=00.
  - P3: write latched WrData[7:0] at SP, RegSel=000.
  - Then FIN.
  - Net effect: mem[SP0-1]=hi, mem[SP0-2]=lo, SP=SP0-2.
- POP:
  - Q1: OutDSel=01, MemCE=1, MemWR=0; PopData[7:0]<=MemRdData; RegSel=010, FunSel=01.
  - Q2: PopData[15:8]<=MemRdData; SP++.
  - Then FIN.
  - PUSH followed by POP restores SP and returns WrData.
- ARINC: SINGLE with RegSel=001, FunSel=01, then FIN.
- CLRPC: SINGLE with RegSel=100, FunSel=11, then FIN.
- NOP: straight to FIN.
- Illegal command: straight to FIN; Err=1 in FIN; no register or memory activity.
- FIN: Done=1 for exactly one cycle, CmdReady=0, then IDLE.
- Latency from accept edge to Done cycle: FETCH 3, PUSH 4, POP 3, ARINC/CLRPC 2, NOP/illegal 1.
- Pointer wrap (0xFFFF+1, 0x0000-1) is the address file's modulo-2^16 behaviour; the sequencer takes no special action.
- Reset assertion:
  - Immediately forces IDLE.
  - Clears IR, PopData and the WrData latch; Done=0, Err=0; all enables deasserted.
  - A partially executed command is abandoned; address file and memory contents already changed are not rolled back.
- Reset release: first accept is possible on the first rising edge after deassertion.

Test Plan:
- Reset mid-PUSH (during P2) -> outputs go to idle values asynchronously, no further MemCE; after release, CmdReady=1 and IR=PopData=0.
- PC=0x0010, mem[0x10]=0x34, mem[0x11]=0x12, FETCH -> IR=0x1234, PC=0x0012, Done exactly 3 cycles after accept, two MemCE read cycles.
- SP=0x0100, PUSH WrData=0xBEEF, then POP -> mem[0xFF]=0xBE, mem[0xFE]=0xEF, SP 0x00FE then 0x0100, PopData=0xBEEF.
- SP=0x0001, PUSH 0xA55A -> writes at 0x0000 then 0xFFFF, SP=0xFFFF; POP returns 0xA55A with SP=0x0001.
- CLRPC with PC=0x7777, ARINC with AR=0xFFFF -> PC=0x0000 and AR=0x0000, each Done 2 cycles after accept.
- Cmd=110 -> Err and Done pulse together 1 cycle after accept, ArfRegSel stays 000; CmdValid held through a FETCH -> only one command accepted until CmdReady returns.
